// File: rtl/rob_tag_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : rob_tag_alloc
//  Description : In-order ROB tag allocator for two dispatch lanes. Hands out
//                consecutive slot tags, tracks the two oldest in-flight tags,
//                advances the head on retirement and rolls the tail back to
//                the first speculative tag on a mispredict flush.
//  Revision    : 1.0  initial release
// ============================================================================
module rob_tag_alloc #(
    parameter int TAG_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 spec_clear,
    input  logic                 alloc_req0,
    input  logic                 alloc_req1,
    input  logic                 spec0_in,
    input  logic                 spec1_in,
    output logic                 alloc_gnt0,
    output logic                 alloc_gnt1,
    output logic [TAG_WIDTH-1:0] tag0,
    output logic [TAG_WIDTH-1:0] tag1,
    input  logic                 retire0,
    input  logic                 retire1,
    output logic [TAG_WIDTH-1:0] oldest0,
    output logic [TAG_WIDTH-1:0] oldest1,
    output logic [TAG_WIDTH:0]   count,
    output logic                 empty,
    output logic                 full,
    output logic                 err
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int             PW      = TAG_WIDTH + 1;
    localparam logic [PW-1:0]  C_DEPTH = PW'(1 << TAG_WIDTH);
    localparam logic [PW-1:0]  C_ONE   = PW'(1);
    localparam logic [PW-1:0]  C_TWO   = PW'(2);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW-1:0] r_ckpt;
    logic          r_ckpt_vld;
    logic          r_err;

    logic [PW-1:0] w_count;
    logic [PW-1:0] w_free;
    logic          w_gnt0;
    logic          w_gnt1;
    logic [PW-1:0] w_nalloc;
    logic [PW-1:0] w_nret;
    logic          w_ret_bad;
    logic          w_ret_hits_ckpt;
    logic          w_spec_gnt0;
    logic          w_spec_gnt1;
    logic          w_set_ckpt;
    logic [PW-1:0] w_ckpt_ptr;

    // Occupancy, grants and retire legality, all from registered state.
    always_comb begin
        w_count     = r_tail - r_head;
        w_free      = C_DEPTH - w_count;
        // Reset and flush both suppress grants; retires in the same cycle
        // never make room for an allocation.
        w_gnt0      = alloc_req0 & ~flush & ~reset & (w_free >= C_ONE);
        w_gnt1      = alloc_req1 & w_gnt0 & (w_free >= C_TWO);
        w_nalloc    = PW'(w_gnt0) + PW'(w_gnt1);
        w_nret      = PW'(retire0) + PW'(retire1);
        // retire1 alone, or retiring more than is allocated, is a protocol
        // violation: the retire is dropped and the error flag latches.
        w_ret_bad   = (retire1 & ~retire0) | (w_count < w_nret);
        // The checkpoint is released once its own tag retires.
        w_ret_hits_ckpt = r_ckpt_vld & retire0 & ~w_ret_bad &
                          ((r_head == r_ckpt) | (retire1 & ((r_head + C_ONE) == r_ckpt)));
        // Only the first speculative grant since the checkpoint was free
        // captures it; lane0 is older so it wins.
        w_spec_gnt0 = w_gnt0 & spec0_in;
        w_spec_gnt1 = w_gnt1 & spec1_in;
        w_set_ckpt  = ~r_ckpt_vld & (w_spec_gnt0 | w_spec_gnt1);
        w_ckpt_ptr  = w_spec_gnt0 ? r_tail : (r_tail + C_ONE);
    end

    // Pointer, checkpoint and error state update; flush has top priority on the tail.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_ckpt     <= '0;
            r_ckpt_vld <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_ret_bad) begin
                r_err <= 1'b1;
            end else begin
                r_head <= r_head + w_nret;
            end

            if (flush) begin
                if (r_ckpt_vld) begin
                    r_tail <= r_ckpt;
                end
                r_ckpt_vld <= 1'b0;
            end else begin
                r_tail <= r_tail + w_nalloc;
                // A new speculative grant re-arms the checkpoint even if a
                // spec_clear for an older branch lands in the same cycle.
                if (w_set_ckpt) begin
                    r_ckpt     <= w_ckpt_ptr;
                    r_ckpt_vld <= 1'b1;
                end else if (w_ret_hits_ckpt | spec_clear) begin
                    r_ckpt_vld <= 1'b0;
                end
            end
        end
    end

    // Output mapping; tags read as 0/1 while reset is held.
    always_comb begin
        alloc_gnt0 = w_gnt0;
        alloc_gnt1 = w_gnt1;
        tag0       = reset ? '0 : r_tail[TAG_WIDTH-1:0];
        tag1       = reset ? TAG_WIDTH'(1) : (r_tail[TAG_WIDTH-1:0] + TAG_WIDTH'(1));
        oldest0    = r_head[TAG_WIDTH-1:0];
        oldest1    = r_head[TAG_WIDTH-1:0] + TAG_WIDTH'(1);
        count      = w_count;
        empty      = (w_count == '0);
        full       = (w_count == C_DEPTH);
        err        = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_tag_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_tag_alloc
//  Description : Scoreboard bench for rob_tag_alloc. A reference model built
//                on unbounded integer head/tail counters predicts every
//                cycle's outputs; a monitor compares them against the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rob_tag_alloc;

    localparam int TW    = 3;
    localparam int DEPTH = 1 << TW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0, spec_clear = 1'b0;
    logic          alloc_req0 = 1'b0, alloc_req1 = 1'b0;
    logic          spec0_in = 1'b0, spec1_in = 1'b0;
    logic          retire0 = 1'b0, retire1 = 1'b0;
    logic          alloc_gnt0, alloc_gnt1, empty, full, err;
    logic [TW-1:0] tag0, tag1, oldest0, oldest1;
    logic [TW:0]   count;

    rob_tag_alloc #(.TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .spec_clear(spec_clear),
        .alloc_req0(alloc_req0), .alloc_req1(alloc_req1),
        .spec0_in(spec0_in), .spec1_in(spec1_in),
        .alloc_gnt0(alloc_gnt0), .alloc_gnt1(alloc_gnt1),
        .tag0(tag0), .tag1(tag1),
        .retire0(retire0), .retire1(retire1),
        .oldest0(oldest0), .oldest1(oldest1),
        .count(count), .empty(empty), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit g0, g1, emp, ful, er;
        int t0, t1, o0, o1, cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: tags are simply positions in an endless sequence.
    int m_head = 0, m_tail = 0, m_ck = 0;
    bit m_vld = 0, m_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // One clock cycle: apply inputs, predict outputs, advance the model.
    task automatic cyc(input bit rq0, input bit rq1, input bit s0, input bit s1,
                       input bit r0, input bit r1, input bit fl, input bit sc, input bit rs);
        exp_t e;
        int   cnt, nret;
        bit   g0, g1, pass_ck;
        @(posedge clk);
        #1;
        alloc_req0 = rq0; alloc_req1 = rq1; spec0_in = s0; spec1_in = s1;
        retire0 = r0; retire1 = r1; flush = fl; spec_clear = sc; reset = rs;

        cnt = m_tail - m_head;
        g0  = rq0 && !fl && !rs && (cnt < DEPTH);
        g1  = rq1 && g0 && (cnt <= DEPTH - 2);
        e.rst = rs;  e.g0 = g0;  e.g1 = g1;
        e.t0  = rs ? 0 : (m_tail % DEPTH);
        e.t1  = rs ? 1 : ((m_tail + 1) % DEPTH);
        e.o0  = m_head % DEPTH;
        e.o1  = (m_head + 1) % DEPTH;
        e.cnt = cnt;
        e.emp = (cnt == 0);
        e.ful = (cnt == DEPTH);
        e.er  = m_err;
        sb.push_back(e);

        if (rs) begin
            m_head = 0; m_tail = 0; m_ck = 0; m_vld = 0; m_err = 0;
            return;
        end
        nret    = int'(r0) + int'(r1);
        pass_ck = 0;
        if ((r1 && !r0) || (cnt < nret)) begin
            m_err = 1;
        end else begin
            pass_ck = m_vld && nret > 0 && (m_ck >= m_head) && (m_ck < m_head + nret);
            m_head += nret;
        end
        if (fl) begin
            if (m_vld) m_tail = m_ck;
            m_vld = 0;
        end else begin
            if (!m_vld && g0 && s0) begin
                m_ck = m_tail; m_vld = 1;
            end else if (!m_vld && g1 && s1) begin
                m_ck = m_tail + 1; m_vld = 1;
            end else if (pass_ck || sc) begin
                m_vld = 0;
            end
            m_tail += int'(g0) + int'(g1);
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pop the prediction for this cycle and compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("gnt0", alloc_gnt0, e.g0);
            check("gnt1", alloc_gnt1, e.g1);
            check("tag0", tag0, e.t0);
            check("tag1", tag1, e.t1);
            if (!e.rst) begin
                check("oldest0", oldest0, e.o0);
                check("oldest1", oldest1, e.o1);
                check("count",   count,   e.cnt);
                check("empty",   empty,   e.emp);
                check("full",    full,    e.ful);
                check("err",     err,     e.er);
            end
        end
    end

    initial begin
        // Test 1: fill the ring two at a time, then it must refuse.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (4) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("t1_full", full, 1);
        check("t1_gnt0_blocked", alloc_gnt0, 0);
        check("t1_gnt1_blocked", alloc_gnt1, 0);

        // Test 2: one free slot grants lane0 only, then a double retire.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("t2_gnt0", alloc_gnt0, 1);
        check("t2_tag0", tag0, 7);
        check("t2_gnt1", alloc_gnt1, 0);
        idle();
        #1;
        check("t2_full", full, 1);
        cyc(0, 0, 0, 0, 1, 1, 0, 0, 0);
        idle();
        #1;
        check("t2_oldest0", oldest0, 2);
        check("t2_oldest1", oldest1, 3);
        check("t2_count", count, 6);

        // Test 3: speculative tags 3..5 discarded by a flush.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        #1;
        check("t3_count", count, 3);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("t3_tag0", tag0, 3);

        // Test 4: branch resolves correct, so a later flush changes nothing.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        #1;
        check("t4_count", count, 6);
        check("t4_tag0", tag0, 6);

        // Test 5: many laps around the ring, ending empty.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (20) begin
            cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 1, 1, 0, 0, 0);
        end
        idle();
        #1;
        check("t5_empty", empty, 1);
        check("t5_oldest0", oldest0, 0);

        // Test 6: illegal retires are dropped and the error is sticky.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle();
        #1;
        check("t6_err", err, 1);
        check("t6_head", oldest0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        #1;
        check("t6_err_sticky", err, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        #1;
        check("t6_err_cleared", err, 0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            bit rq0, rq1, s0, s1, r0, r1, fl, sc, rs;
            rs  = ($urandom % 200) == 0;
            fl  = ($urandom % 16) == 0;
            sc  = ($urandom % 12) == 0;
            rq0 = ($urandom % 4) != 0;
            rq1 = $urandom % 2;
            s0  = ($urandom % 3) == 0;
            s1  = ($urandom % 3) == 0;
            r0  = ($urandom % 3) != 0;
            r1  = ($urandom % 2) == 0;
            if (fl) begin
                r0 = 0; r1 = 0;
            end
            cyc(rq0, rq1, s0, s1, r0, r1, fl, sc, rs);
        end

        // Allow the monitor to consume the last predictions.
        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
